mem_loader: RTL
===============

MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 SHALL have parameter memWords, default 100, number of 32-bit words in each of IM and DM.
REQ-002 SHALL have parameter RELEASE_CYC, default 2, cycles core_rst stays high after the last memory write.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port s_valid, input, 1, a program word is present on s_data.
REQ-006 SHALL have port s_ready, output, 1, the loader accepts a word this cycle.
REQ-007 SHALL have port s_data, input, 32, the program word (hex image order, word 0 first).
REQ-008 SHALL have port s_last, input, 1, marks the final image word; qualified by s_valid.
REQ-009 SHALL have port im_we, output, 1, instruction-memory word write enable.
REQ-010 SHALL have port dm_we, output, 1, data-memory word write enable.
REQ-011 SHALL have port mem_addr, output, 32, word index shared by IM and DM writes.
REQ-012 SHALL have port mem_wdata, output, 32, write data shared by IM and DM.
REQ-013 SHALL have port core_rst, output, 1, reset to the core; high until loading completes.
REQ-014 SHALL have port done, output, 1, image loaded and core released.
REQ-015 SHALL have port overflow, output, 1, sticky flag: the image held more than memWords words.

Function
REQ-016 SHALL implement the states LOAD, FILL, RELEASE and RUN.
REQ-017 A word SHALL be accepted on a cycle where s_valid and s_ready are both high.
REQ-018 In LOAD, s_ready SHALL be 1 and the other outputs SHALL be as listed under REQ-019 to REQ-021.
REQ-019 In LOAD, an accepted word with addr < memWords SHALL drive im_we=dm_we=1, mem_addr=addr and mem_wdata=s_data in the same cycle (combinational, zero latency), and addr SHALL then increment.
REQ-020 In LOAD, an accepted word with addr >= memWords SHALL NOT be written; overflow SHALL be set the next cycle and stay set; addr SHALL saturate.
REQ-021 In LOAD, when s_valid is low or no word is accepted, im_we and dm_we SHALL be 0.
REQ-022 Accepting a word with s_last=1 SHALL move LOAD to FILL if the post-increment addr < memWords, otherwise to RELEASE.
REQ-023 In FILL, s_ready SHALL be 0 and each cycle SHALL write 0 to mem_addr=addr (im_we=dm_we=1) and increment addr.
REQ-024 FILL SHALL move to RELEASE after the cycle that writes word memWords-1.
REQ-025 In RELEASE, s_ready, im_we and dm_we SHALL be 0, core_rst SHALL be 1, and a counter SHALL run RELEASE_CYC cycles before moving to RUN.
REQ-026 In RUN, core_rst SHALL be 0, done SHALL be 1 and s_ready SHALL be 0.
REQ-027 RUN SHALL be terminal; any s_valid input in RUN SHALL be ignored.
REQ-028 core_rst SHALL be 1 in every state except RUN.
REQ-029 An empty image (first accepted word has s_last=1) SHALL write that word at 0, then zero-fill words 1 to memWords-1.
REQ-030 s_valid held high with s_ready=0 SHALL cause no write and no state change.

Reset
REQ-031 rst=1 at a clock edge SHALL force state LOAD, addr=0, the release counter to 0, overflow=0, done=0 and core_rst=1.
REQ-032 While rst=1, s_ready, im_we and dm_we SHALL be 0.
REQ-033 rst asserted mid-LOAD or mid-FILL SHALL abort the load; the next load SHALL restart at word 0.

Structure
REQ-034 A shared package SHALL hold the state enum (LOAD, FILL, RELEASE, RUN) and the word-width constant 32.
REQ-035 The block SHALL be one module with no sub-modules.
REQ-036 The block SHALL sit between the bench or host stream and the top-level IM and DM write ports, replacing the bench's backdoor image load.

Verification
REQ-037 Stream 5 words 0x00000013 .. 0x00500093 with last on word 4, memWords=100 -> words 0-4 are written to IM and DM, words 5-99 read 0, core_rst falls exactly 2 cycles after the word-99 write, done=1.
REQ-038 Stream 100 words with last on word 99 -> FILL is skipped, RELEASE follows directly, overflow=0.
REQ-039 Stream 103 words with last on word 102 -> only words 0-99 are written, overflow=1 from the cycle after word 100 is accepted, done=1 afterwards.
REQ-040 Toggle s_valid randomly in LOAD (e.g. 1,0,0,1,1) -> the write count equals the accepted-word count, and mem_addr is contiguous with no gaps.
REQ-041 Assert rst while writing word 40 of FILL -> next cycle im_we=0, core_rst=1, addr=0; a reloaded 3-word image writes starting at word 0.
REQ-042 In RUN, drive s_valid=1 and s_data=0xDEADBEEF -> no writes occur, done stays 1 and core_rst stays 0.

Source files
------------

// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg: shared loader state encoding and word width.
package mem_loader_pkg;
    localparam int WORD_W = 32;
    typedef enum logic [1:0] {LOAD, FILL, RELEASE, RUN} state_t;
endpackage

// File: rtl/mem_loader_if.sv
// mem_loader_if: program-word stream in, IM/DM write port and core control out.
interface mem_loader_if;
    import mem_loader_pkg::*;
    logic              s_valid;
    logic              s_ready;
    logic [WORD_W-1:0] s_data;
    logic              s_last;
    logic              im_we;
    logic              dm_we;
    logic [WORD_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              core_rst;
    logic              done;
    logic              overflow;
    modport slave (
        input  s_valid, s_data, s_last,
        output s_ready, im_we, dm_we, mem_addr, mem_wdata, core_rst, done, overflow
    );
    modport master (
        output s_valid, s_data, s_last,
        input  s_ready, im_we, dm_we, mem_addr, mem_wdata, core_rst, done, overflow
    );
endinterface

// File: rtl/mem_loader.sv
// mem_loader: streams a program image into IM/DM, zero-fills the rest, then releases the core.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int memWords    = 100,
    parameter int RELEASE_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    mem_loader_if.slave bus
);
    localparam int AW = $clog2(memWords + 1);
    localparam int CW = (RELEASE_CYC > 1) ? $clog2(RELEASE_CYC) : 1;
    localparam logic [AW-1:0] ADDR_END = AW'(memWords);
    localparam logic [AW-1:0] ADDR_TOP = AW'(memWords - 1);
    localparam logic [CW-1:0] CNT_END  = CW'(RELEASE_CYC - 1);

    state_t        r_state, w_next;
    logic [AW-1:0] r_addr, w_addr;
    logic [CW-1:0] r_cnt;
    logic          r_ovf;
    logic          w_ready, w_we, w_room, w_ovf_set;

    always_comb begin
        w_room    = r_addr < ADDR_END;
        w_next    = r_state;
        w_addr    = r_addr;
        w_ready   = 1'b0;
        w_we      = 1'b0;
        w_ovf_set = 1'b0;
        case (r_state)
            LOAD: begin
                w_ready = 1'b1;
                if (bus.s_valid) begin
                    w_we      = w_room;
                    w_ovf_set = !w_room;
                    w_addr    = w_room ? r_addr + 1'b1 : r_addr;
                    if (bus.s_last) w_next = (w_addr < ADDR_END) ? FILL : RELEASE;
                end
            end
            FILL: begin
                w_we   = 1'b1;
                w_addr = r_addr + 1'b1;
                if (r_addr == ADDR_TOP) w_next = RELEASE;
            end
            RELEASE: if (r_cnt == CNT_END) w_next = RUN;
            default: ;
        endcase
        // reset must silence the memory port in the very cycle it is asserted
        if (rst) begin
            w_ready = 1'b0;
            w_we    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LOAD;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_addr  <= w_addr;
            r_cnt   <= (r_state == RELEASE) ? r_cnt + 1'b1 : '0;
            r_ovf   <= r_ovf | w_ovf_set;
        end
    end

    assign bus.s_ready   = w_ready;
    assign bus.im_we     = w_we;
    assign bus.dm_we     = w_we;
    assign bus.mem_addr  = WORD_W'(r_addr);
    assign bus.mem_wdata = (r_state == LOAD) ? bus.s_data : '0;
    assign bus.core_rst  = rst || (r_state != RUN);
    assign bus.done      = !rst && (r_state == RUN);
    assign bus.overflow  = r_ovf;
endmodule
